// File: rtl/demux_1to8_tdm_if.sv
// Serial lane and frame outputs of the 1-to-8 TDM demultiplexer.
// The master drives the serial bits; the slave (the demux) returns the assembled frame and status.
interface demux_1to8_tdm_if;
    logic       i_en;
    logic       i_din;
    logic       i_sync;
    logic [7:0] o_y;
    logic       o_y_valid;
    logic       o_locked;
    logic       o_sync_err;
    logic [2:0] o_slot;

    modport master (
        output i_en, i_din, i_sync,
        input  o_y, o_y_valid, o_locked, o_sync_err, o_slot
    );

    modport slave (
        input  i_en, i_din, i_sync,
        output o_y, o_y_valid, o_locked, o_sync_err, o_slot
    );
endinterface

// File: rtl/demux_1to8_tdm.sv
// Receive end of an 8-slot TDM lane: tracks slot position from the frame-sync marker,
// assembles 8-bit frames and delivers only frames that began while locked.
module demux_1to8_tdm #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    demux_1to8_tdm_if.slave bus
);
    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [3:0] LF       = 4'(LOCK_FRAMES);
    // State entered whenever a sync bit starts a fresh count of one good marker.
    localparam state_t     ST_FRESH = (LOCK_FRAMES == 1) ? LOCKED : CHECK;

    state_t     r_state,    w_state_nx;
    logic [2:0] r_slot,     w_slot_nx;
    logic [3:0] r_good,     w_good_nx;
    logic [6:0] r_shadow,   w_shadow_nx;
    logic       r_deliver,  w_deliver_nx;
    logic [7:0] r_y,        w_y_nx;
    logic       r_y_valid,  w_y_valid_nx;
    logic       r_sync_err, w_sync_err_nx;
    logic [3:0] w_good_inc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= HUNT;
            r_slot     <= '0;
            r_good     <= '0;
            r_shadow   <= '0;
            r_deliver  <= 1'b0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_slot     <= w_slot_nx;
            r_good     <= w_good_nx;
            r_shadow   <= w_shadow_nx;
            r_deliver  <= w_deliver_nx;
            r_y        <= w_y_nx;
            r_y_valid  <= w_y_valid_nx;
            r_sync_err <= w_sync_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_slot_nx     = r_slot;
        w_good_nx     = r_good;
        w_shadow_nx   = r_shadow;
        w_deliver_nx  = r_deliver;
        w_y_nx        = r_y;
        w_y_valid_nx  = 1'b0;
        w_sync_err_nx = 1'b0;
        w_good_inc    = (r_good == 4'd15) ? 4'd15 : r_good + 4'd1;

        if (bus.i_en) begin
            if (r_state == HUNT) begin
                if (bus.i_sync) begin
                    w_shadow_nx[0] = bus.i_din;
                    w_slot_nx      = 3'd1;
                    w_good_nx      = 4'd1;
                    w_state_nx     = ST_FRESH;
                    w_deliver_nx   = (ST_FRESH == LOCKED);
                end
            end else if (r_slot == 3'd0) begin
                if (bus.i_sync) begin
                    w_good_nx = w_good_inc;
                    if (r_state == CHECK && w_good_inc >= LF)
                        w_state_nx = LOCKED;
                    w_shadow_nx[0] = bus.i_din;
                    w_slot_nx      = 3'd1;
                    w_deliver_nx   = (w_state_nx == LOCKED);
                end else begin
                    w_sync_err_nx = 1'b1;
                    w_state_nx    = HUNT;
                    w_good_nx     = '0;
                    w_slot_nx     = '0;
                    w_deliver_nx  = 1'b0;
                end
            end else if (bus.i_sync) begin
                // Misplaced marker: trust it as the new slot 0 and restart the good count.
                w_sync_err_nx  = 1'b1;
                w_state_nx     = ST_FRESH;
                w_good_nx      = 4'd1;
                w_shadow_nx[0] = bus.i_din;
                w_slot_nx      = 3'd1;
                w_deliver_nx   = (ST_FRESH == LOCKED);
            end else begin
                if (r_slot == 3'd7) begin
                    if (r_deliver && r_state == LOCKED) begin
                        w_y_nx       = {bus.i_din, r_shadow};
                        w_y_valid_nx = 1'b1;
                    end
                    w_deliver_nx = 1'b0;
                end else begin
                    w_shadow_nx[r_slot] = bus.i_din;
                end
                w_slot_nx = r_slot + 3'd1;
            end
        end
    end

    assign bus.o_y        = r_y;
    assign bus.o_y_valid  = r_y_valid;
    assign bus.o_locked   = (r_state == LOCKED);
    assign bus.o_sync_err = r_sync_err;
    assign bus.o_slot     = r_slot;
endmodule
